serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's serial sequence detectors (e.g. the 1101 Moore detector) and drives their single-bit `x` input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock, with a qualifying valid and an end-of-word marker.
- Supports gapless back-to-back words, so detectors see a continuous stream across word boundaries and overlapping matches spanning words are preserved.

Parameters:
- WIDTH, 8, bits per word; legal range ≥ 2.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to load.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the downstream detector.
- x_valid  output  1  x carries a real data bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on x.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; shift register = 0; bit counter = 0.
  - Outputs during and after reset until the first load: x = 0, x_valid = 0, word_done = 0, din_ready = 1.
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight; counter cnt runs 0..WIDTH-1 and cnt = k means bit k of the transmit order is on x.
- din_ready:
  - Combinational: (state == IDLE) OR (state == SHIFT AND cnt == WIDTH-1).
  - It never depends on din_valid.
- Accept: din_valid AND din_ready at a rising edge.
  - On accept: shift register <= din; cnt <= 0; state <= SHIFT.
- Latency: the first bit of an accepted word appears on x in the cycle after the accepting edge.
- SHIFT, cnt < WIDTH-1:
  - Each edge shifts the register one position toward the output end: left when MSB_FIRST = 1, right when MSB_FIRST = 0.
  - Vacated bit fills with 0; cnt increments.
  - din_valid is ignored because din_ready = 0.
- SHIFT, cnt = WIDTH-1 (last bit on x):
  - Accept: reload with no bubble; the next word's first bit is on x in the following cycle and x_valid stays 1.
  - No accept: state <= IDLE; cnt <= 0.
- Outputs:
  - x = output-end bit of the shift register when state == SHIFT, otherwise 0. Idle gaps therefore look like 0s to the downstream detector.
  - x_valid = (state == SHIFT).
  - word_done = (state == SHIFT) AND (cnt == WIDTH-1). It is combinational and high for exactly one cycle per word.
- x and x_valid come straight from flops through a single gate level, with no combinational path from din or din_valid. din_ready and word_done are the only outputs decoded from state/cnt.
- Counter width: $clog2(WIDTH). cnt never exceeds WIDTH-1; no wrap beyond that.
- Reset mid-word: the in-flight word is discarded with no partial word_done, and outputs immediately take their reset values.
- din may change while din_ready = 0 with no effect. din is sampled only on the accepting edge.

Decomposition:
- Shared package, e.g. seq_det_pkg, holds:
  - state encoding constants: IDLE = 1'b0, SHIFT = 1'b1.
  - the default WIDTH constant, so the feeder and the detector test harnesses agree.
- No sub-module is needed. The shift register, counter and 2-state FSM stay in one module of roughly 120–160 lines.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with din_valid = 1 → x = 0, x_valid = 0, word_done = 0, din_ready = 1 throughout; no load occurs.
- Single word, WIDTH = 8, MSB_FIRST = 1: din = 8'b1101_1010 accepted at edge 0 → x = 1,1,0,1,1,0,1,0 on cycles 1–8; x_valid = 1 on cycles 1–8; word_done only on cycle 8; x_valid = 0 on cycle 9.
- Back-to-back: 8'hD5 then 8'h0D, with din_valid held high → 16 contiguous valid bits with no gap; second word accepted exactly on the word_done cycle of the first; din_ready = 0 during cycles 1–7.
- LSB-first, MSB_FIRST = 0: din = 8'b0000_1011 → x = 1,1,0,1,0,0,0,0. Chained into the 1101 detector, its z asserts once, one cycle after the fourth bit.
- Reset mid-word: assert rst = 0 after bit 3 of 8'hFF → x and x_valid drop to 0 asynchronously; word_done never pulses; the next word after release starts at its bit 0.
- Idle gap: 8'hF0, two idle cycles, then 8'h0F → x = 0 and x_valid = 0 during the gap; din_ready = 1 in the gap; the second word's first bit is on x the cycle after its accept.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial feeder and the sequence-detector harnesses.
package seq_det_pkg;

  // Feeder FSM encoding
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_e;

  // Default word width so the feeder and the detector harnesses agree
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-in / serial-out feeder for the single-bit sequence detectors.
// Words are loaded over a valid/ready handshake. One bit is emitted per clock.
// A new word can be loaded on the last bit of the previous one, so consecutive
// words reach the detector as one continuous, gapless stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word in flight; x/x_valid are 0 and din_ready is 1
// SHIFT | word in flight; cnt = k means bit k of transmit order is on x
module serial_bit_feeder
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  feeder_state_e  state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic last_bit;
  logic accept;
  logic out_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Handshake decode: ready while idle or on the last bit, which allows a gapless reload
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = (state_q == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;
  assign word_done = last_bit;

  // Shift direction and output end come from MSB_FIRST; the vacated bit fills with 0
  always_comb begin
    sreg_shifted = '0;
    out_bit      = 1'b0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      out_bit      = sreg_q[WIDTH-1];
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      out_bit      = sreg_q[0];
    end
  end

  // x is gated by state so that idle gaps look like 0s to the detector.
  // The path from the flops is one gate deep, and x does not depend on din.
  assign x_valid = (state_q == SHIFT);
  assign x       = x_valid & out_bit;

  // Next-state logic for the FSM, shift register and bit counter
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = din;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // State, shift register and counter flops; reset discards any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder. It drives an MSB-first instance and
// an LSB-first instance from the same handshake.
module tb_serial_bit_feeder;

  localparam int W = 8;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready_w [2];
  logic         x_w         [2];
  logic         x_valid_w   [2];
  logic         word_done_w [2];

  exp_bit_t     sb [2][$];
  int           n_vec;
  int           n_err;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_w[0]),
    .x         (x_w[0]),
    .x_valid   (x_valid_w[0]),
    .word_done (word_done_w[0])
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_w[1]),
    .x         (x_w[1]),
    .x_valid   (x_valid_w[1]),
    .word_done (word_done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare both instances against their scoreboards.
  // When a scoreboard is empty, the instance must be idle with din_ready high.
  task automatic monitor();
    exp_bit_t e;
    for (int i = 0; i < 2; i++) begin
      if (sb[i].size() > 0) begin
        e = sb[i].pop_front();
        check($sformatf("x_valid[%0d]", i), 32'(x_valid_w[i]), 32'd1);
        check($sformatf("x[%0d]", i), 32'(x_w[i]), 32'(e.b));
        check($sformatf("word_done[%0d]", i), 32'(word_done_w[i]), 32'(e.last));
      end else begin
        check($sformatf("x_valid_idle[%0d]", i), 32'(x_valid_w[i]), 32'd0);
        check($sformatf("x_idle[%0d]", i), 32'(x_w[i]), 32'd0);
        check($sformatf("word_done_idle[%0d]", i), 32'(word_done_w[i]), 32'd0);
      end
      check($sformatf("din_ready[%0d]", i), 32'(din_ready_w[i]), 32'(sb[i].size() == 0));
    end
  endtask

  // One clock: check outputs, drive inputs, and predict whether the next edge accepts
  task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
    exp_bit_t e;
    @(negedge clk);
    monitor();
    din_valid = v;
    din       = d;
    #1;
    acc = rst && v && (sb[0].size() == 0);
    if (acc) begin
      for (int k = 0; k < W; k++) begin
        e.last = (k == W - 1);
        e.b    = d[W-1-k];
        sb[0].push_back(e);
        e.b    = d[k];
        sb[1].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h5A, acc);
  endtask

  task automatic send(input logic [W-1:0] word);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < W + 4) begin
      cycle(1'b1, word, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Assert reset between edges: outputs must drop immediately and the in-flight word is dropped
  task automatic reset_mid();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_x[%0d]", i), 32'(x_w[i]), 32'd0);
      check($sformatf("rst_x_valid[%0d]", i), 32'(x_valid_w[i]), 32'd0);
      check($sformatf("rst_word_done[%0d]", i), 32'(word_done_w[i]), 32'd0);
      check($sformatf("rst_din_ready[%0d]", i), 32'(din_ready_w[i]), 32'd1);
      sb[i].delete();
    end
  endtask

  initial begin
    logic acc;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    din_valid = 1'b1;
    din       = 8'hAA;

    // Hold reset for three cycles with din_valid high; no load may occur
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, acc);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;

    // Single word, then let it drain so x_valid is seen to drop
    send(8'b1101_1010);
    idle(10);

    // Back-to-back words with din_valid held high: expect no gap
    send(8'hD5);
    send(8'h0D);
    idle(10);

    // Idle gap of two cycles between words
    send(8'hF0);
    idle(8);
    idle(2);
    send(8'h0F);
    idle(10);

    // Reset after bit 3 of 8'hFF
    send(8'hFF);
    idle(3);
    @(negedge clk);
    monitor();
    reset_mid();
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'h77, acc);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;

    // The next word must start at bit 0; LSB-first it reads 1,1,0,1,0,0,0,0
    send(8'b0000_1011);
    idle(10);

    // Gapless run with a mix of words
    send(8'hA5);
    send(8'h3C);
    send(8'h81);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
